aes_round_radix: RTL
====================

AES_ROUND_RADIX -- requirements
Module: aes_round_radix

Interface
REQ-001 SHALL have parameter BYTES_PER_CYCLE, default 1, the number of state bytes through S-box/GF multiply per cycle; legal values 1, 2, 4.
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset, synchronous and active-low.
REQ-004 SHALL have port in_valid, input, 1, request holds a valid round job.
REQ-005 SHALL have port in_ready, output, 1, block accepts a job this cycle.
REQ-006 SHALL have port mode, input, 2, key size: 00 AES-128, 01 AES-192, 10 AES-256, 11 treated as AES-256.
REQ-007 SHALL have port round, input, 4, round number of the job.
REQ-008 SHALL have port data_in, input, 128, state; byte 0 = [127:120], FIPS-197 column-major order.
REQ-009 SHALL have port round_key, input, 128, key for this round.
REQ-010 SHALL have port out_valid, output, 1, data_out holds a result.
REQ-011 SHALL have port out_ready, input, 1, consumer takes the result.
REQ-012 SHALL have port data_out, output, 128, round result.
REQ-013 SHALL have port round_err, output, 1, qualified by out_valid; round exceeded the mode's last round.

Function
REQ-014 SHALL capture mode, round, data_in and round_key on in_valid & in_ready; inputs are ignored otherwise.
REQ-015 SHALL implement FSM IDLE -> (round==0 or round>LAST ? ARK : SUB) -> ... -> ARK -> OUT.
REQ-016 SUB SHALL last N = 16/BYTES_PER_CYCLE cycles, with a byte counter from 0 stepping by BYTES_PER_CYCLE, so bytes are consumed in ascending index (column 0 first).
REQ-017 In SUB, each byte SHALL be ShiftRows-selected, S-boxed, and multiplied by {02} and {03}; completed columns are MixColumns-recombined into the state register.
REQ-018 LAST = 10/12/14 for mode 00/01/10-11; when round==LAST, MixColumns SHALL be bypassed (SubBytes+ShiftRows only).
REQ-019 ARK SHALL last 1 cycle and load data_out with the working state XOR the captured round_key.
REQ-020 The working state SHALL be the captured data_in when round==0 or round>LAST.
REQ-021 round>LAST SHALL set round_err=1 with the result; otherwise round_err=0.
REQ-022 Latency from acceptance to out_valid SHALL be N+2 cycles for rounds 1..LAST and 2 cycles otherwise.
REQ-023 OUT SHALL hold out_valid, data_out and round_err stable until out_ready; the transfer completes on out_valid & out_ready.
REQ-024 in_ready SHALL equal IDLE | (OUT & out_ready); a simultaneous output transfer and new acceptance go directly OUT -> SUB/ARK with no bubble.
REQ-025 in_ready SHALL be 0 in SUB and ARK; in_valid there SHALL have no effect.

Reset
REQ-026 While rst_n=0 at a clock edge: FSM -> IDLE; counter, data_out and round_err -> 0; out_valid -> 0; in_ready -> 1 from the next cycle.
REQ-027 Reset mid-SUB/ARK/OUT SHALL discard the job with no out_valid pulse.

Structure
REQ-028 Package aes_pkg SHALL hold the mode enum, the state enum, LAST_ROUND constants (10/12/14) and the byte-index helpers.
REQ-029 The S-box and GF {02}/{03} multipliers SHALL be reused, replicated BYTES_PER_CYCLE times.
REQ-030 Column recombination SHALL be a single sub-module aes_mixcol_word (4 bytes plus 02/03 products in, 32-bit mixed column out).
REQ-031 An elaboration-time assertion SHALL reject BYTES_PER_CYCLE outside {1,2,4}.

Verification
REQ-032 mode=00, round=1, data_in=193de3bea0f4e22b9ac68d2ae9f84808, key=a0fafe1788542cb123a339392a6c7605 -> data_out=a49c7ff2689f352b6b5bea43026a5049 at N+2 cycles, for each BYTES_PER_CYCLE value.
REQ-033 mode=00, round=0, data_in=3243f6a8885a308d313198a2e0370734, key=2b7e151628aed2a6abf7158809cf4f3c -> 193de3bea0f4e22b9ac68d2ae9f84808 after 2 cycles.
REQ-034 mode=00, round=10, data_in=eb40f21e592e38848ba113e71bc342d2, key=d014f9a8c9ee2589e13f0cc8b6630ca6 -> 3925841d02dc09fbdc118597196a0b32 (no MixColumns).
REQ-035 mode=00, round=11 -> round_err=1, data_out=data_in^key; the same data with mode=10 -> round_err=0 with a MixColumns result.
REQ-036 Hold out_ready=0 for 5 cycles, then assert it with in_valid=1 -> data_out stable throughout, back-to-back acceptance, next result N+2 cycles later.
REQ-037 rst_n=0 for one cycle mid-SUB -> no out_valid, in_ready=1 the next cycle, and a fresh job completes correctly.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES round types and helpers: key-size mode, FSM state, last-round
// constants, FIPS-197 byte indexing and the GF(2^8) S-box/multiply functions.
// No ports; imported by aes_round_radix and aes_mixcol_word.
package aes_pkg;

  typedef enum logic [1:0] {
    MODE_AES128     = 2'b00,
    MODE_AES192     = 2'b01,
    MODE_AES256     = 2'b10,
    MODE_AES256_ALT = 2'b11
  } aes_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SUB  = 2'd1,
    ST_ARK  = 2'd2,
    ST_OUT  = 2'd3
  } aes_state_e;

  localparam logic [3:0] LAST_ROUND_128 = 4'd10;
  localparam logic [3:0] LAST_ROUND_192 = 4'd12;
  localparam logic [3:0] LAST_ROUND_256 = 4'd14;

  function automatic logic [3:0] last_round(input aes_mode_e m);
    logic [3:0] r;
    case (m)
      MODE_AES128: r = LAST_ROUND_128;
      MODE_AES192: r = LAST_ROUND_192;
      default:     r = LAST_ROUND_256;
    endcase
    return r;
  endfunction

  // Byte idx of the state, byte 0 in the top 8 bits (column-major order).
  function automatic logic [7:0] state_byte(input logic [127:0] s, input logic [3:0] idx);
    logic [127:0] t;
    t = s << {idx, 3'b000};
    return t[127:120];
  endfunction

  // ShiftRows: output (row r, col c) comes from input (row r, col c+r mod 4).
  function automatic logic [3:0] shift_rows_src(input logic [3:0] idx);
    logic [1:0] r;
    logic [1:0] c;
    r = idx[1:0];
    c = idx[3:2];
    return {c + r, r};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // Inverse as x^254 (x^2 * x^4 * ... * x^128), which also maps 0 to 0,
  // followed by the affine transform written as byte rotations.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] p;
    logic [7:0] inv;
    p   = x;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p   = gf_mul(p, p);
      inv = gf_mul(inv, p);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

endpackage

// File: rtl/aes_mixcol_word.sv
// Purpose: MixColumns for one column from S-boxed bytes and their {02}/{03} products.
// Latency: combinational. Backpressure: none (pure function).
// Ports: s_in/m2_in/m3_in indexed by row 0..3; col_out = {row0,row1,row2,row3}.
module aes_mixcol_word
  import aes_pkg::*;
(
  input  logic [3:0][7:0] s_in,
  input  logic [3:0][7:0] m2_in,
  input  logic [3:0][7:0] m3_in,
  output logic [31:0]     col_out
);

  logic [7:0] r0, r1, r2, r3;

  assign r0 = m2_in[0] ^ m3_in[1] ^ s_in[2]  ^ s_in[3];
  assign r1 = s_in[0]  ^ m2_in[1] ^ m3_in[2] ^ s_in[3];
  assign r2 = s_in[0]  ^ s_in[1]  ^ m2_in[2] ^ m3_in[3];
  assign r3 = m3_in[0] ^ s_in[1]  ^ s_in[2]  ^ m2_in[3];

  assign col_out = {r0, r1, r2, r3};

endmodule

// File: rtl/aes_round_radix.sv
// Purpose: one AES encryption round, BYTES_PER_CYCLE state bytes per SUB cycle.
// Latency: 16/BYTES_PER_CYCLE+2 cycles for rounds 1..LAST, 2 otherwise; one job in flight.
// Backpressure: result held in OUT until out_ready; in_ready only in IDLE or OUT&out_ready.
// Ports: clk/rst_n (sync, active-low); in_valid/in_ready with mode, round, data_in,
// round_key; out_valid/out_ready with data_out and round_err.
module aes_round_radix
  import aes_pkg::*;
#(
  parameter int BYTES_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   mode,
  input  logic [3:0]   round,
  input  logic [127:0] data_in,
  input  logic [127:0] round_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] data_out,
  output logic         round_err
);

  if (BYTES_PER_CYCLE != 1 && BYTES_PER_CYCLE != 2 && BYTES_PER_CYCLE != 4) begin : g_bpc_illegal
    $error("aes_round_radix: BYTES_PER_CYCLE must be 1, 2 or 4");
  end

  aes_state_e      state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [127:0]    in_q, in_d;
  logic [127:0]    key_q, key_d;
  logic [3:0][31:0] work_q, work_d;
  logic            sub_q, sub_d;
  logic            final_q, final_d;
  logic            err_q, err_d;
  logic [127:0]    data_out_q, data_out_d;
  logic            round_err_q, round_err_d;
  logic            out_valid_q, out_valid_d;
  logic [3:0][7:0] col_s_q, col_s_d;
  logic [3:0][7:0] col_m2_q, col_m2_d;
  logic [3:0][7:0] col_m3_q, col_m3_d;

  logic [7:0]  lane_s  [BYTES_PER_CYCLE];
  logic [7:0]  lane_m2 [BYTES_PER_CYCLE];
  logic [7:0]  lane_m3 [BYTES_PER_CYCLE];
  logic [31:0] mixed;
  logic [31:0] shifted;
  logic [1:0]  last_row;
  logic        col_done;
  logic        accept;
  logic [3:0]  job_last;

  assign in_ready  = (state_q == ST_IDLE) | ((state_q == ST_OUT) & out_ready);
  assign accept    = in_valid & in_ready;
  assign out_valid = out_valid_q;
  assign data_out  = data_out_q;
  assign round_err = round_err_q;
  assign job_last  = last_round(aes_mode_e'(mode));

  // Lane k handles output byte cnt+k: fetch its ShiftRows source, S-box it,
  // and form the {02}/{03} products MixColumns will need.
  for (genvar k = 0; k < BYTES_PER_CYCLE; k++) begin : g_lane
    logic [3:0] idx;
    assign idx        = cnt_q + 4'(k);
    assign lane_s[k]  = sbox(state_byte(in_q, shift_rows_src(idx)));
    assign lane_m2[k] = xtime(lane_s[k]);
    assign lane_m3[k] = lane_m2[k] ^ lane_s[k];
  end

  // Column staging: this cycle's lanes merged over the partially filled column.
  always_comb begin
    col_s_d  = col_s_q;
    col_m2_d = col_m2_q;
    col_m3_d = col_m3_q;
    if (state_q == ST_SUB) begin
      for (int k = 0; k < BYTES_PER_CYCLE; k++) begin
        col_s_d[cnt_q[1:0] + 2'(k)]  = lane_s[k];
        col_m2_d[cnt_q[1:0] + 2'(k)] = lane_m2[k];
        col_m3_d[cnt_q[1:0] + 2'(k)] = lane_m3[k];
      end
    end
  end

  // The column is complete when the highest lane lands on row 3.
  assign last_row = cnt_q[1:0] + 2'(BYTES_PER_CYCLE - 1);
  assign col_done = (last_row == 2'd3);
  assign shifted  = {col_s_d[0], col_s_d[1], col_s_d[2], col_s_d[3]};

  aes_mixcol_word u_mixcol (
    .s_in    (col_s_d),
    .m2_in   (col_m2_d),
    .m3_in   (col_m3_d),
    .col_out (mixed)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    in_d        = in_q;
    key_d       = key_q;
    work_d      = work_q;
    sub_d       = sub_q;
    final_d     = final_q;
    err_d       = err_q;
    data_out_d  = data_out_q;
    round_err_d = round_err_q;
    out_valid_d = out_valid_q;

    case (state_q)
      ST_IDLE: ;
      ST_SUB: begin
        cnt_d = cnt_q + 4'(BYTES_PER_CYCLE);
        if (col_done) begin
          // work_q[3] is column 0 (most significant word).
          work_d[2'd3 - cnt_q[3:2]] = final_q ? shifted : mixed;
        end
        if (cnt_q == 4'(16 - BYTES_PER_CYCLE)) state_d = ST_ARK;
      end
      ST_ARK: begin
        data_out_d  = (sub_q ? work_q : in_q) ^ key_q;
        round_err_d = err_q;
        out_valid_d = 1'b1;
        state_d     = ST_OUT;
      end
      ST_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Acceptance overrides OUT -> IDLE so a new job starts with no bubble.
    if (accept) begin
      in_d    = data_in;
      key_d   = round_key;
      cnt_d   = 4'd0;
      err_d   = (round > job_last);
      final_d = (round == job_last);
      sub_d   = (round != 4'd0) && (round <= job_last);
      state_d = sub_d ? ST_SUB : ST_ARK;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      in_q        <= '0;
      key_q       <= '0;
      work_q      <= '0;
      sub_q       <= 1'b0;
      final_q     <= 1'b0;
      err_q       <= 1'b0;
      data_out_q  <= '0;
      round_err_q <= 1'b0;
      out_valid_q <= 1'b0;
      col_s_q     <= '0;
      col_m2_q    <= '0;
      col_m3_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      in_q        <= in_d;
      key_q       <= key_d;
      work_q      <= work_d;
      sub_q       <= sub_d;
      final_q     <= final_d;
      err_q       <= err_d;
      data_out_q  <= data_out_d;
      round_err_q <= round_err_d;
      out_valid_q <= out_valid_d;
      col_s_q     <= col_s_d;
      col_m2_q    <= col_m2_d;
      col_m3_q    <= col_m3_d;
    end
  end

endmodule
